// File: rtl/key_sw_entry_if.sv
// Pushbutton/switch entry bus: raw board inputs in, entered hex value and key events out.
interface key_sw_entry_if #(
  parameter int DIGITS = 6
);
  logic [1:0]          KEY;
  logic [9:0]          SW;
  logic [4*DIGITS-1:0] value;
  logic [3:0]          digit_count;
  logic                full;
  logic [1:0]          key_evt;

  modport master (
    output KEY,
    output SW,
    input  value,
    input  digit_count,
    input  full,
    input  key_evt
  );

  modport slave (
    input  KEY,
    input  SW,
    output value,
    output digit_count,
    output full,
    output key_evt
  );
endinterface

// File: rtl/key_sw_entry.sv
// Hex digit entry from debounced pushbuttons: enter shifts in SW[3:0], clear zeroes the register.
module key_sw_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DIGITS          = 6
) (
  input  logic           CLOCK_50,
  input  logic           Reset,
  key_sw_entry_if.slave  bus
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int             VW       = 4 * DIGITS;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]     CNT_FULL = 4'(DIGITS);

  logic [1:0]    r_key_p0, r_key_p1;
  logic [4:0]    r_sw_p0, r_sw_p1;
  logic [CW-1:0] r_cnt [2];
  logic [1:0]    r_stable, r_stable_d;
  logic [VW-1:0] r_value;
  logic [3:0]    r_count;
  logic [1:0]    r_evt;
  logic [1:0]    w_press;
  logic          w_full;
  logic [VW-1:0] w_shifted;

  // Stage 0/1: two-flop synchronisers; only SW[9] and SW[3:0] carry meaning
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_key_p0 <= '1;
      r_key_p1 <= '1;
      r_sw_p0  <= '1;
      r_sw_p1  <= '1;
    end else begin
      r_key_p0 <= bus.KEY;
      r_key_p1 <= r_key_p0;
      r_sw_p0  <= {bus.SW[9], bus.SW[3:0]};
      r_sw_p1  <= r_sw_p0;
    end
  end

  // Stage 2: per-key debouncer; any return to the stable level restarts the count
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      for (int k = 0; k < 2; k++) r_cnt[k] <= '0;
      r_stable   <= '1;
      r_stable_d <= '1;
    end else begin
      r_stable_d <= r_stable;
      for (int k = 0; k < 2; k++) begin
        if (r_key_p1[k] == r_stable[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == CNT_LAST) begin
          r_stable[k] <= r_key_p1[k];
          r_cnt[k]    <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + 1'b1;
        end
      end
    end
  end

  // A press is a debounced high-to-low step; releases are ignored
  assign w_press = r_stable_d & ~r_stable;
  assign w_full  = (r_count == CNT_FULL);

  generate
    if (DIGITS == 1) begin : g_one
      assign w_shifted = r_sw_p1[3:0];
    end else begin : g_many
      assign w_shifted = {r_value[VW-5:0], r_sw_p1[3:0]};
    end
  endgenerate

  // Stage 3: entry register; clear beats a simultaneous enter
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_value <= '0;
      r_count <= '0;
      r_evt   <= '0;
    end else begin
      r_evt <= w_press;
      if (w_press[1]) begin
        r_value <= '0;
        r_count <= '0;
      end else if (w_press[0]) begin
        if (!w_full) begin
          r_value <= w_shifted;
          r_count <= r_count + 4'd1;
        end else if (r_sw_p1[4]) begin
          r_value <= w_shifted;
        end
      end
    end
  end

  assign bus.value       = r_value;
  assign bus.digit_count = r_count;
  assign bus.full        = w_full;
  assign bus.key_evt     = r_evt;

endmodule

// File: doc/key_sw_entry.md
KEY_SW_ENTRY -- requirements
Module: key_sw_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, number of consecutive synchronised clocks a key level must hold before it is accepted (10 ms at 50 MHz); legal range >= 2.
REQ-002 Parameter DIGITS, default 6, number of 4-bit hex digits held in the entry register; legal range 1..8.
REQ-003 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 KEY  input  2  raw active-low pushbuttons; KEY[0] = enter, KEY[1] = clear.
REQ-006 SW  input  10  raw switches; SW[3:0] = digit to enter, SW[9] = overwrite-when-full enable, SW[8:4] unused.
REQ-007 value  output  4*DIGITS  entered hex value, most recent digit in bits [3:0].
REQ-008 digit_count  output  4  number of digits entered, saturating at DIGITS.
REQ-009 full  output  1  high when digit_count == DIGITS.
REQ-010 key_evt  output  2  one-cycle pulse per accepted press: [0] enter, [1] clear.

Function
REQ-011 KEY and SW SHALL each pass through a 2-flop synchroniser before any other use.
REQ-012 Each key SHALL have an independent debouncer: stable level, counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-013 Debouncer: synchronised level == stable -> counter cleared; differs -> counter increments; at counter == DEBOUNCE_CYCLES-1 with level still differing -> stable takes the level, counter clears.
REQ-014 Any return to the stable level before acceptance SHALL clear the counter; glitches shorter than DEBOUNCE_CYCLES synchronised cycles produce no event.
REQ-015 A press is a stable 1->0 transition; a release (0->1) SHALL produce no event.
REQ-016 key_evt SHALL be registered: for KEY held low continuously, key_evt is high for exactly the one cycle following edge DEBOUNCE_CYCLES+3, counted from the first edge sampling KEY low.
REQ-017 The value/digit_count update for a press SHALL occur on the same edge that sets key_evt.
REQ-018 Enter press, not full: value <= {value[4*DIGITS-5:0], SW_sync[3:0]}; digit_count increments.
REQ-019 Enter press, full, SW_sync[9]=1: same shift; oldest digit discarded; digit_count stays DIGITS.
REQ-020 Enter press, full, SW_sync[9]=0: value and digit_count unchanged; key_evt[0] still pulses.
REQ-021 Clear press: value <= 0, digit_count <= 0.
REQ-022 Clear and enter accepted on the same edge: clear wins, enter discarded; both key_evt bits pulse.
REQ-023 Holding a key low SHALL give exactly one event; a new event requires a debounced release then press.
REQ-024 SW digit is sampled from the synchronised SW on the update edge, not at the physical press.
REQ-025 full SHALL be combinational from digit_count.

Reset
REQ-026 Reset SHALL set value=0, digit_count=0, key_evt=0, debounce counters=0, stable levels=1 (released), synchroniser flops=1.
REQ-027 Reset mid-debounce SHALL abort the pending press with no event.
REQ-028 Reset SHALL take priority over every press on the same edge.
REQ-029 A key held low through reset deassertion SHALL yield one press, timed per REQ-016 from the first post-reset edge.

Verification (DEBOUNCE_CYCLES=4, DIGITS=6)
REQ-030 Reset, SW=0x005, KEY[0] low from edge 1 -> key_evt[0] high only after edge 7; value=0x000005, digit_count=1.
REQ-031 KEY[0] low for 3 cycles then high -> no key_evt, value unchanged.
REQ-032 Enter digits 1..6 -> value=0x123456, full=1; enter 7 with SW[9]=0 -> value unchanged; with SW[9]=1 -> value=0x234567, count=6.
REQ-033 KEY[0] and KEY[1] pressed on the same cycle with value=0x00ABCD -> key_evt=2'b11, value=0, digit_count=0.
REQ-034 Reset asserted 2 cycles into a KEY[0] debounce -> no event, all outputs 0; KEY[0] held -> one event 7 edges after reset deasserts.
REQ-035 KEY[0] held low 50 cycles -> exactly one key_evt[0] pulse, digit_count +1.
